// File: rtl/csi2_csr_bank_if.sv
// AXI4-Lite slave bus bundle for the CSI-2 CSR bank.
interface csi2_csr_bank_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr_i;
    logic                    awvalid_i;
    logic                    awready_o;
    logic [DATA_WIDTH-1:0]   wdata_i;
    logic [DATA_WIDTH/8-1:0] wstrb_i;
    logic                    wvalid_i;
    logic                    wready_o;
    logic [1:0]              bresp_o;
    logic                    bvalid_o;
    logic                    bready_i;
    logic [ADDR_WIDTH-1:0]   araddr_i;
    logic                    arvalid_i;
    logic                    arready_o;
    logic [DATA_WIDTH-1:0]   rdata_o;
    logic [1:0]              rresp_o;
    logic                    rvalid_o;
    logic                    rready_i;

    modport slave (
        input  awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
               araddr_i, arvalid_i, rready_i,
        output awready_o, wready_o, bresp_o, bvalid_o,
               arready_o, rdata_o, rresp_o, rvalid_o
    );

    modport master (
        output awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
               araddr_i, arvalid_i, rready_i,
        input  awready_o, wready_o, bresp_o, bvalid_o,
               arready_o, rdata_o, rresp_o, rvalid_o
    );
endinterface

// File: rtl/csi2_csr_bank.sv
// AXI4-Lite control/status register bank: CRs with pulse and shadow/commit modes,
// SRs sampled from sr_i, byte strobes and SLVERR on unmapped indices.
module csi2_csr_bank #(
    parameter int                          DATA_WIDTH  = 32,
    parameter int                          ADDR_WIDTH  = 8,
    parameter int                          CR_CNT      = 6,
    parameter int                          SR_CNT      = 7,
    parameter logic [CR_CNT*DATA_WIDTH-1:0] CR_RST_VAL = '0,
    parameter logic [CR_CNT-1:0]           PULSE_MASK  = 6'b100001,
    parameter logic [CR_CNT-1:0]           SHADOW_MASK = 6'b011000,
    parameter int                          COMMIT_IDX  = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    csi2_csr_bank_if.slave               bus,
    output logic [CR_CNT*DATA_WIDTH-1:0] cr_o,
    output logic [CR_CNT-1:0]            cr_upd_o,
    input  logic [SR_CNT*DATA_WIDTH-1:0] sr_i
);
    localparam int         IDX_W       = ADDR_WIDTH - 2;
    localparam int         STRB_W      = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                  ready_en_reg;
    logic                  aw_held_reg;
    logic                  w_held_reg;
    logic [IDX_W-1:0]      aw_idx_reg;
    logic [DATA_WIDTH-1:0] w_data_reg;
    logic [STRB_W-1:0]     w_strb_reg;
    logic                  bvalid_reg;
    logic [1:0]            bresp_reg;
    logic                  rvalid_reg;
    logic [1:0]            rresp_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;

    logic                  aw_hs, w_hs, ar_hs, exec, commit_fire;
    logic [IDX_W-1:0]      wr_idx, ar_idx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_err;
    logic [DATA_WIDTH-1:0] cr_rd [CR_CNT];
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{bus.awaddr_i[1:0], bus.araddr_i[1:0]};

    assign bus.awready_o = ready_en_reg && !aw_held_reg && !bvalid_reg;
    assign bus.wready_o  = ready_en_reg && !w_held_reg && !bvalid_reg;
    assign bus.arready_o = ready_en_reg && !rvalid_reg;
    assign bus.bvalid_o  = bvalid_reg;
    assign bus.bresp_o   = bresp_reg;
    assign bus.rvalid_o  = rvalid_reg;
    assign bus.rresp_o   = rresp_reg;
    assign bus.rdata_o   = rdata_reg;

    assign aw_hs  = bus.awvalid_i && bus.awready_o;
    assign w_hs   = bus.wvalid_i && bus.wready_o;
    assign ar_hs  = bus.arvalid_i && bus.arready_o;
    assign wr_idx = aw_hs ? bus.awaddr_i[ADDR_WIDTH-1:2] : aw_idx_reg;
    assign ar_idx = bus.araddr_i[ADDR_WIDTH-1:2];

    // Both halves held only in the execute cycle; bvalid is already up by then.
    assign exec        = aw_held_reg && w_held_reg;
    assign commit_fire = exec && (aw_idx_reg == IDX_W'(COMMIT_IDX)) && w_strb_reg[0] && w_data_reg[0];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ready_en_reg <= 1'b0;
            aw_held_reg  <= 1'b0;
            w_held_reg   <= 1'b0;
            aw_idx_reg   <= '0;
            w_data_reg   <= '0;
            w_strb_reg   <= '0;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= RESP_OKAY;
        end else begin
            ready_en_reg <= 1'b1;
            if (exec) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
            end
            if (aw_hs) begin
                aw_held_reg <= 1'b1;
                aw_idx_reg  <= bus.awaddr_i[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_held_reg <= 1'b1;
                w_data_reg <= bus.wdata_i;
                w_strb_reg <= bus.wstrb_i;
            end
            if ((aw_held_reg || aw_hs) && (w_held_reg || w_hs) && !bvalid_reg) begin
                bvalid_reg <= 1'b1;
                bresp_reg  <= (wr_idx < IDX_W'(CR_CNT)) ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_reg && bus.bready_i) begin
                bvalid_reg <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < CR_CNT; gi++) begin : g_cr
        logic [DATA_WIDTH-1:0] shadow_reg;
        logic [DATA_WIDTH-1:0] applied_reg;
        logic                  upd_reg;
        logic [DATA_WIDTH-1:0] merged;
        logic [DATA_WIDTH-1:0] strobed;
        logic                  hit;

        assign hit = exec && (aw_idx_reg == IDX_W'(gi)) && (|w_strb_reg);

        for (genvar bi = 0; bi < STRB_W; bi++) begin : g_lane
            assign merged[bi*8 +: 8]  = w_strb_reg[bi] ? w_data_reg[bi*8 +: 8] : shadow_reg[bi*8 +: 8];
            assign strobed[bi*8 +: 8] = w_strb_reg[bi] ? w_data_reg[bi*8 +: 8] : 8'h00;
        end

        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                shadow_reg  <= PULSE_MASK[gi] ? '0 : CR_RST_VAL[gi*DATA_WIDTH +: DATA_WIDTH];
                applied_reg <= PULSE_MASK[gi] ? '0 : CR_RST_VAL[gi*DATA_WIDTH +: DATA_WIDTH];
                upd_reg     <= 1'b0;
            end else if (PULSE_MASK[gi]) begin
                applied_reg <= hit ? strobed : '0;
                upd_reg     <= hit;
            end else if (SHADOW_MASK[gi]) begin
                if (hit) shadow_reg <= merged;
                if (commit_fire) applied_reg <= shadow_reg;
                upd_reg <= commit_fire;
            end else begin
                if (hit) begin
                    shadow_reg  <= merged;
                    applied_reg <= merged;
                end
                upd_reg <= hit;
            end
        end

        assign cr_o[gi*DATA_WIDTH +: DATA_WIDTH] = applied_reg;
        assign cr_upd_o[gi]                      = upd_reg;
        assign cr_rd[gi]                         = PULSE_MASK[gi] ? '0 : shadow_reg;
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b1;
        for (int i = 0; i < CR_CNT; i++) begin
            if (ar_idx == IDX_W'(i)) begin
                rd_data = cr_rd[i];
                rd_err  = 1'b0;
            end
        end
        for (int j = 0; j < SR_CNT; j++) begin
            if (ar_idx == IDX_W'(CR_CNT + j)) begin
                rd_data = sr_i[j*DATA_WIDTH +: DATA_WIDTH];
                rd_err  = 1'b0;
            end
        end
    end

    // Read data is captured at AR handshake so SR values stay frozen until R completes.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
            rresp_reg  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rd_data;
            rresp_reg  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_reg && bus.rready_i) begin
            rvalid_reg <= 1'b0;
        end
    end
endmodule

// File: doc/csi2_csr_bank.md
Name: csi2_csr_bank

Overview:
- Parametrised AXI4-Lite control/status register bank for the CSI-2 receiver; it generalises the fixed CR/SR index map to arbitrary counts.
- Control registers (CRs) drive PHY and deskew configuration.
- Status registers (SRs) expose error and line/pixel statistics counters.
- Adds per-register pulse (self-clearing) mode, shadowed CRs with atomic commit, byte strobes and bus error responses.

Parameters:
- DATA_WIDTH, 32, register and bus data width; must be 32.
- ADDR_WIDTH, 8, AXI address width; register index = addr[ADDR_WIDTH-1:2].
- CR_CNT, 6, number of control registers; indices 0..CR_CNT-1.
- SR_CNT, 7, number of status registers; indices CR_CNT..CR_CNT+SR_CNT-1.
- CR_RST_VAL, '0, packed CR_CNT*DATA_WIDTH reset values; CR i occupies slice i.
- PULSE_MASK, 6'b100001, bit i=1: CR i is a one-cycle pulse register.
- SHADOW_MASK, 6'b011000, bit i=1: CR i is shadowed and applied only on commit.
- COMMIT_IDX, 5, index of the commit CR; must have its PULSE_MASK bit set.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- awaddr_i  in  ADDR_WIDTH  write address
- awvalid_i  in  1  write address valid
- awready_o  out  1  write address ready
- wdata_i  in  DATA_WIDTH  write data
- wstrb_i  in  DATA_WIDTH/8  byte strobes
- wvalid_i  in  1  write data valid
- wready_o  out  1  write data ready
- bresp_o  out  2  write response: 00 OKAY, 10 SLVERR
- bvalid_o  out  1  write response valid
- bready_i  in  1  write response ready
- araddr_i  in  ADDR_WIDTH  read address
- arvalid_i  in  1  read address valid
- arready_o  out  1  read address ready
- rdata_o  out  DATA_WIDTH  read data
- rresp_o  out  2  read response
- rvalid_o  out  1  read data valid
- rready_i  in  1  read data ready
- cr_o  out  CR_CNT*DATA_WIDTH  applied CR values
- cr_upd_o  out  CR_CNT  one-cycle pulse: applied value of CR i written/updated
- sr_i  in  SR_CNT*DATA_WIDTH  status inputs, synchronous to clk_i

Behaviour:
Reset (rst_n_i low at a rising edge):
- Shadow and applied CRs load CR_RST_VAL; pulse-mode CRs load 0.
- All valid/ready outputs go low except awready_o, wready_o and arready_o, which go high in the first cycle after reset release.
- bresp_o, rresp_o and rdata_o are 0; cr_upd_o is 0.
- Reset mid-transaction drops the in-flight transaction; no B or R beat is issued.

Write channel:
- AW and W are captured independently into holding registers.
- awready_o is high when no AW is held and bvalid_o is low; wready_o is high when no W is held and bvalid_o is low.
- The write executes in the cycle after both are held (AW and W in the same cycle is allowed), and bvalid_o rises in that same cycle.
- Holding registers clear on execute.
- bvalid_o holds until bready_i; bresp_o is stable while bvalid_o is high.
- Minimum write latency: AW+W handshake cycle to bvalid_o = 1 cycle.

Write decode:
- Index < CR_CNT: byte lanes with wstrb set update the shadow register; bresp OKAY.
- Index in the SR range or beyond CR_CNT+SR_CNT-1: no state change; bresp SLVERR.
- wstrb = 0 to a valid CR: OKAY, no change, no cr_upd_o pulse.

CR application:
- Non-shadowed, non-pulse CR: the applied value equals the shadow value from the cycle after execute; cr_upd_o[i] pulses in that same cycle.
- Pulse CR: cr_o slice carries the written value for exactly one cycle (the cycle after execute), then returns to 0; cr_upd_o[i] pulses.
- Shadowed CR: a write updates the shadow only; cr_o is unchanged.
- Commit: a write to COMMIT_IDX with wdata[0]=1 copies all shadowed CRs to applied in the cycle after execute and pulses cr_upd_o for every shadowed CR and COMMIT_IDX.
- A write to COMMIT_IDX with wdata[0]=0 only pulses cr_upd_o[COMMIT_IDX].

Read channel:
- arready_o = !rvalid_o.
- On AR handshake, rdata_o and rresp_o are registered; rvalid_o rises the next cycle and holds until rready_i.
- Reads of a CR return the shadow value; pulse CRs read 0.
- Reads of an SR return sr_i sampled in the AR handshake cycle and are frozen until the R handshake.
- Out-of-range reads return rdata 0 and rresp SLVERR.
- A read handshake in the same cycle as a write execute to the same CR returns the pre-write value.

Bus independence:
- Read and write channels are fully independent; concurrent operation is required.
- Back-to-back reads: the next AR is accepted in the cycle after the R handshake.

Test Plan:
- Release reset with CR_RST_VAL slice 2 = 0x42 -> cr_o slice 2 = 0x42 and cr_o slice 3 = CR_RST_VAL slice 3; first read of index 2 returns 0x42 with rresp 00.
- Write 0xA5A5_1234, wstrb 4'b0011, to CR 2 (value 0xFFFF_FFFF) -> next cycle cr_o slice 2 = 0xFFFF_1234, cr_upd_o = 6'b000100, bresp 00.
- Write 7 to CR 3 and 9 to CR 4 -> cr_o unchanged and readback returns 7/9; then write 1 to CR 5 -> both apply in the same cycle and cr_upd_o = 6'b111000.
- Write 1 to CR 0 -> cr_o slice 0 = 1 for exactly one cycle, then 0; a read of index 0 returns 0.
- Drive sr_i slice 0 = 17, issue a read of index 6 and change sr_i to 18 while rready_i is held low for 3 cycles -> rdata_o stays 17.
- Write index 8, read index 20, and send AW 3 cycles before W -> SLVERR on both; rdata 0; no cr_o change; bvalid_o rises 1 cycle after the W handshake.
